ddr_rd_arbiter: RTL and testbench

Two-requester arbiter for the single DDR AXI read channel (128-bit data, INCR bursts). Requester 0 is the HDMI framebuffer reader; requester 1 is the CPU/game asset reader (sprites, tiles). The block grants one burst at a time, forwards the winner's address to the DDR controller, and routes read beats back to the owner until `rlast`. It tracks the burst beat count and flags any mismatch between the requested length and the observed `rlast`.

---
 rtl/ddr_rd_arbiter_if.sv | 48 ++++
 rtl/ddr_rd_arbiter.sv | 138 +++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_arbiter_if.sv
// Bundled requester-side and DDR-side read-channel signals of the two-port DDR read arbiter.
// The master modport is the arbiter's view; slave is the surrounding requesters plus DDR controller.
interface ddr_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0] s0_araddr;
    logic [ADDR_W-1:0] s1_araddr;
    logic [7:0]        s0_arlen;
    logic [7:0]        s1_arlen;
    logic              s0_arvalid;
    logic              s1_arvalid;
    logic              s0_arready;
    logic              s1_arready;
    logic              s0_urgent;
    logic              s0_rvalid;
    logic              s1_rvalid;
    logic              s0_rready;
    logic              s1_rready;
    logic [DATA_W-1:0] s_rdata;
    logic              s_rlast;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_rlast;
    logic              m_rready;

    modport master (
        input  s0_araddr, s1_araddr, s0_arlen, s1_arlen, s0_arvalid, s1_arvalid,
        input  s0_urgent, s0_rready, s1_rready,
        output s0_arready, s1_arready, s0_rvalid, s1_rvalid, s_rdata, s_rlast,
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  m_arready, m_rdata, m_rvalid, m_rlast
    );

    modport slave (
        output s0_araddr, s1_araddr, s0_arlen, s1_arlen, s0_arvalid, s1_arvalid,
        output s0_urgent, s0_rready, s1_rready,
        input  s0_arready, s1_arready, s0_rvalid, s1_rvalid, s_rdata, s_rlast,
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output m_arready, m_rdata, m_rvalid, m_rlast
    );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Two-requester arbiter for the DDR AXI read channel: one burst at a time, urgent/round-robin
// grant, combinational beat routing to the owner and sticky burst-length mismatch detection.
module ddr_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    ddr_rd_arbiter_if.master     bus,
    output logic                 busy,
    output logic                 len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              len_err_q, len_err_d;

    logic              win;
    logic              ar_valid;
    logic              ar_ready0;
    logic              ar_ready1;
    logic              rvalid0;
    logic              rvalid1;
    logic              rready;
    logic              beat;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        len_err_d    = len_err_q;
        win          = 1'b0;
        ar_valid     = 1'b0;
        ar_ready0    = 1'b0;
        ar_ready1    = 1'b0;
        rvalid0      = 1'b0;
        rvalid1      = 1'b0;
        rready       = 1'b0;
        beat         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.s0_arvalid || bus.s1_arvalid) begin
                    // urgent or sole s0 -> s0; sole s1 -> s1; tie -> whoever did not win last
                    if (bus.s0_arvalid && (bus.s0_urgent || !bus.s1_arvalid)) begin
                        win = 1'b0;
                    end else if (!bus.s0_arvalid) begin
                        win = 1'b1;
                    end else begin
                        win = ~last_grant_q;
                    end
                    owner_d      = win;
                    last_grant_d = win;
                    addr_d       = win ? bus.s1_araddr : bus.s0_araddr;
                    len_d        = win ? bus.s1_arlen : bus.s0_arlen;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                ar_valid = 1'b1;
                if (bus.m_arready) begin
                    ar_ready0 = ~owner_q;
                    ar_ready1 = owner_q;
                    cnt_d     = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                rready  = owner_q ? bus.s1_rready : bus.s0_rready;
                rvalid0 = ~owner_q & bus.m_rvalid;
                rvalid1 = owner_q & bus.m_rvalid;
                beat    = bus.m_rvalid & rready;
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    // rlast must coincide exactly with the beat whose count equals len
                    if (bus.m_rlast != (cnt_q == len_q)) begin
                        len_err_d = 1'b1;
                    end
                    if (bus.m_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata          = bus.m_rdata;
    assign bus.s_rdata    = rdata;
    assign bus.s_rlast    = bus.m_rlast;
    assign bus.s0_arready = ar_ready0;
    assign bus.s1_arready = ar_ready1;
    assign bus.s0_rvalid  = rvalid0;
    assign bus.s1_rvalid  = rvalid1;
    assign bus.m_araddr   = addr_q;
    assign bus.m_arlen    = len_q;
    assign bus.m_arsize   = 3'b100;
    assign bus.m_arburst  = 2'b01;
    assign bus.m_arvalid  = ar_valid;
    assign bus.m_rready   = rready;
    assign busy           = (state_q != IDLE);
    assign len_err        = len_err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: grant order, routing, back-pressure, length errors, reset.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
module tb_ddr_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic len_err;

    int n_cmp = 0;
    int n_bad = 0;

    ddr_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .busy    (busy),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_arvalid"}, 128'(bus.m_arvalid), 128'(0));
        check({tag, "_m_rready"},  128'(bus.m_rready),  128'(0));
        check({tag, "_s0_arready"}, 128'(bus.s0_arready), 128'(0));
        check({tag, "_s1_arready"}, 128'(bus.s1_arready), 128'(0));
        check({tag, "_s0_rvalid"}, 128'(bus.s0_rvalid), 128'(0));
        check({tag, "_s1_rvalid"}, 128'(bus.s1_rvalid), 128'(0));
        check({tag, "_busy"},      128'(busy),          128'(0));
        check({tag, "_len_err"},   128'(len_err),       128'(0));
        check({tag, "_m_araddr"},  128'(bus.m_araddr),  128'(0));
        check({tag, "_m_arlen"},   128'(bus.m_arlen),   128'(0));
        check({tag, "_m_arsize"},  128'(bus.m_arsize),  128'(4));
        check({tag, "_m_arburst"}, 128'(bus.m_arburst), 128'(1));
    endtask

    // Caller has just raised the request(s) in IDLE; returns 1 unit after the edge entering DATA.
    task automatic issue(input int own, input logic [31:0] addr, input logic [7:0] len, input int delay);
        #1;
        check("arvalid_before_decision", 128'(bus.m_arvalid), 128'(0));
        tick();
        #1;
        check("arvalid_rise", 128'(bus.m_arvalid), 128'(1));
        check("araddr", 128'(bus.m_araddr), 128'(addr));
        check("arlen", 128'(bus.m_arlen), 128'(len));
        check("busy_in_addr", 128'(busy), 128'(1));
        check("arready_no_handshake", 128'({bus.s0_arready, bus.s1_arready}), 128'(0));
        for (int d = 0; d < delay; d++) begin
            tick();
            #1;
            check("arvalid_hold", 128'(bus.m_arvalid), 128'(1));
            check("arready_wait_ddr", 128'({bus.s0_arready, bus.s1_arready}), 128'(0));
        end
        bus.m_arready = 1'b1;
        #1;
        check("s0_arready_pulse", 128'(bus.s0_arready), 128'(own == 0));
        check("s1_arready_pulse", 128'(bus.s1_arready), 128'(own == 1));
        tick();
        bus.m_arready = 1'b0;
    endtask

    // Streams beats until nacc are accepted; beat last_idx carries rlast. evt_at raises
    // s0 urgent+request and an s1 re-request at that beat index.
    task automatic beats(input int own, input int id, input int nacc, input int last_idx,
                         input bit toggle, input int evt_at);
        int i = 0;
        int cyc = 0;
        bit rr;
        logic [127:0] exp_data;
        while (i < nacc && cyc < 400) begin
            rr = toggle ? (cyc % 2 == 0) : 1'b1;
            if (own == 0) begin
                bus.s0_rready = rr;
                bus.s1_rready = ~rr;
            end else begin
                bus.s1_rready = rr;
                bus.s0_rready = ~rr;
            end
            exp_data     = {32'(id), 64'd0, 32'(i)};
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = exp_data;
            bus.m_rlast  = (i == last_idx);
            if (i == evt_at) begin
                bus.s0_arvalid = 1'b1;
                bus.s0_urgent  = 1'b1;
                bus.s1_arvalid = 1'b1;
            end
            #1;
            check("m_rready_mirror", 128'(bus.m_rready), 128'(rr));
            check("rvalid_owner", 128'(own == 0 ? bus.s0_rvalid : bus.s1_rvalid), 128'(1));
            check("rvalid_other", 128'(own == 0 ? bus.s1_rvalid : bus.s0_rvalid), 128'(0));
            check("arready_during_data", 128'({bus.s0_arready, bus.s1_arready}), 128'(0));
            if (rr) begin
                check("rdata", bus.s_rdata, exp_data);
                check("rlast", 128'(bus.s_rlast), 128'(i == last_idx));
                i++;
            end
            cyc++;
            tick();
        end
        check("beats_accepted", 128'(i), 128'(nacc));
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        #1;
        check("busy_after_burst", 128'(busy), 128'(last_idx == nacc - 1 ? 0 : 1));
    endtask

    initial begin
        rst            = 1'b1;
        bus.s0_araddr  = '0;
        bus.s1_araddr  = '0;
        bus.s0_arlen   = '0;
        bus.s1_arlen   = '0;
        bus.s0_arvalid = 1'b0;
        bus.s1_arvalid = 1'b0;
        bus.s0_urgent  = 1'b0;
        bus.s0_rready  = 1'b0;
        bus.s1_rready  = 1'b0;
        bus.m_arready  = 1'b0;
        bus.m_rdata    = '0;
        bus.m_rvalid   = 1'b0;
        bus.m_rlast    = 1'b0;
        repeat (3) tick();
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // s1 only, 64-beat burst, DDR address ready delayed 3 cycles
        bus.s1_araddr  = 32'h0030_0000;
        bus.s1_arlen   = 8'd63;
        bus.s1_arvalid = 1'b1;
        issue(1, 32'h0030_0000, 8'd63, 3);
        bus.s1_arvalid = 1'b0;
        beats(1, 1, 64, 63, 1'b0, -1);
        check("t1_len_err", 128'(len_err), 128'(0));

        // both requesting from reset: strict alternation starting with s0
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.s0_araddr  = 32'h1000_0000;
        bus.s1_araddr  = 32'h2000_0000;
        bus.s0_arlen   = 8'd3;
        bus.s1_arlen   = 8'd3;
        bus.s0_arvalid = 1'b1;
        bus.s1_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue(0, 32'h1000_0000 + 32'(k) * 32'h100, 8'd3, 0);
            bus.s0_araddr = bus.s0_araddr + 32'h100;
            beats(0, 10 + 2 * k, 4, 3, 1'b0, -1);
            issue(1, 32'h2000_0000 + 32'(k) * 32'h100, 8'd3, 0);
            bus.s1_araddr = bus.s1_araddr + 32'h100;
            beats(1, 11 + 2 * k, 4, 3, 1'b0, -1);
        end
        bus.s0_arvalid = 1'b0;
        bus.s1_arvalid = 1'b0;

        // urgent raised mid s1 burst; urgent then overrides round-robin; then tie resumes
        bus.s1_araddr  = 32'h3000_0000;
        bus.s1_arlen   = 8'd7;
        bus.s0_arlen   = 8'd7;
        bus.s1_arvalid = 1'b1;
        issue(1, 32'h3000_0000, 8'd7, 0);
        bus.s1_arvalid = 1'b0;
        bus.s0_araddr  = 32'h4000_0000;
        bus.s1_araddr  = 32'h3000_1000;
        beats(1, 30, 8, 7, 1'b0, 3);
        issue(0, 32'h4000_0000, 8'd7, 0);
        bus.s0_araddr = 32'h4000_1000;
        beats(0, 31, 8, 7, 1'b0, -1);
        issue(0, 32'h4000_1000, 8'd7, 1);
        bus.s0_urgent = 1'b0;
        bus.s0_araddr = 32'h4000_2000;
        beats(0, 32, 8, 7, 1'b0, -1);
        issue(1, 32'h3000_1000, 8'd7, 0);
        bus.s1_arvalid = 1'b0;
        beats(1, 33, 8, 7, 1'b0, -1);
        issue(0, 32'h4000_2000, 8'd7, 0);
        bus.s0_arvalid = 1'b0;
        beats(0, 34, 8, 7, 1'b0, -1);

        // s0 64-beat burst with rready toggling every cycle
        bus.s0_araddr  = 32'h0080_0000;
        bus.s0_arlen   = 8'd63;
        bus.s0_arvalid = 1'b1;
        issue(0, 32'h0080_0000, 8'd63, 2);
        bus.s0_arvalid = 1'b0;
        beats(0, 40, 64, 63, 1'b1, -1);
        check("t4_len_err", 128'(len_err), 128'(0));

        // early rlast on beat 32 of a len-63 burst; error is sticky across a good burst
        bus.s1_araddr  = 32'h0050_0000;
        bus.s1_arlen   = 8'd63;
        bus.s1_arvalid = 1'b1;
        issue(1, 32'h0050_0000, 8'd63, 0);
        bus.s1_arvalid = 1'b0;
        beats(1, 50, 32, 31, 1'b0, -1);
        check("early_rlast_len_err", 128'(len_err), 128'(1));
        bus.s0_araddr  = 32'h0060_0000;
        bus.s0_arlen   = 8'd3;
        bus.s0_arvalid = 1'b1;
        issue(0, 32'h0060_0000, 8'd3, 0);
        bus.s0_arvalid = 1'b0;
        beats(0, 51, 4, 3, 1'b0, -1);
        check("len_err_sticky", 128'(len_err), 128'(1));

        // reset at beat 10 of a burst, with a beat still presented by DDR
        bus.s0_araddr  = 32'h0070_0000;
        bus.s0_arlen   = 8'd63;
        bus.s0_arvalid = 1'b1;
        issue(0, 32'h0070_0000, 8'd63, 0);
        bus.s0_arvalid = 1'b0;
        beats(0, 60, 10, -1, 1'b0, -1);
        bus.m_rvalid  = 1'b1;
        bus.s0_rready = 1'b1;
        bus.s1_rready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        bus.m_rvalid = 1'b0;
        bus.s1_araddr  = 32'h0090_0000;
        bus.s1_arlen   = 8'd3;
        bus.s1_arvalid = 1'b1;
        issue(1, 32'h0090_0000, 8'd3, 0);
        bus.s1_arvalid = 1'b0;
        beats(1, 61, 4, 3, 1'b0, -1);
        check("post_reset_len_err", 128'(len_err), 128'(0));

        // missing rlast at count==len (len 1, rlast arrives on third beat)
        bus.s1_araddr  = 32'h00A0_0000;
        bus.s1_arlen   = 8'd1;
        bus.s1_arvalid = 1'b1;
        issue(1, 32'h00A0_0000, 8'd1, 0);
        bus.s1_arvalid = 1'b0;
        beats(1, 70, 3, 2, 1'b0, -1);
        check("late_rlast_len_err", 128'(len_err), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
